cpu_break_sequencer: RTL and testbench

//  Run/halt/single-step sequencer for the 6502 front-panel monitor. Drives the CPU NMI line and switches the
//  top page ($FF00-$FFFF) between user RAM and the monitor control RAM (overlay). Sits beside cpu_control.

---
 rtl/cpu_break_sequencer_pkg.sv | 16 +
 rtl/cpu_break_sequencer.sv | 128 ++++++++++++
 tb/tb_cpu_break_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_break_sequencer_pkg.sv
// Shared constants and state encoding for the 6502 front-panel break sequencer.
// REG_BASE is the monitor register dump offset, also used by cpu_control's readout.
package cpu_break_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_ARMED   = 2'd1,
    ST_OVERLAY = 2'd2
  } seq_state_e;

  localparam logic [15:0] NMI_VEC    = 16'hFFFA;
  localparam logic [15:0] NMI_VEC_HI = 16'hFFFB;
  localparam logic [7:0]  OVL_PAGE   = 8'hFF;
  localparam logic [7:0]  REG_BASE   = 8'hF0;

endpackage

// File: rtl/cpu_break_sequencer.sv
// Run/halt/single-step sequencer: drives CPU NMI and selects control RAM for the $FF page
// while the monitor runs. FSM, ARMED timeout counter and address decode are all inline.
module cpu_break_sequencer
  import cpu_break_sequencer_pkg::*;
#(
  parameter int ARM_TIMEOUT = 1024,
  parameter int TMO_W       = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_en,
  input  logic [15:0] A,
  input  logic        rw,
  input  logic        sync,
  input  logic        b_runhalt,
  input  logic        b_step,
  output logic        nmi_n,
  output logic        overlay,
  output logic        halted,
  output logic        cont,
  output logic [1:0]  state
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ARM_TIMEOUT - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic             r_run_mode;
  logic             w_run_next;
  logic             r_nmi_n;
  logic             w_nmi_next;
  logic             r_cont;
  logic             w_cont_next;
  logic [TMO_W-1:0] r_cnt;
  logic [TMO_W-1:0] w_cnt_next;
  logic             w_vec_addr;
  logic             w_ovl_page;
  logic             w_step;

  assign w_vec_addr = (A == NMI_VEC) || (A == NMI_VEC_HI);
  assign w_ovl_page = (A[15:8] == OVL_PAGE);
  assign w_run_next = r_run_mode ^ b_runhalt;
  // A simultaneous run/halt press takes priority; the step press is discarded.
  assign w_step     = b_step & ~b_runhalt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_NORMAL;
      r_run_mode <= 1'b1;
      r_nmi_n    <= 1'b1;
      r_cont     <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_run_mode <= w_run_next;
      r_nmi_n    <= w_nmi_next;
      r_cont     <= w_cont_next;
      r_cnt      <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_nmi_next   = r_nmi_n;
    w_cont_next  = r_cont;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_NORMAL: begin
        if (!w_run_next) begin
          w_state_next = ST_ARMED;
          w_nmi_next   = 1'b0;
          w_cnt_next   = '0;
        end
      end
      ST_ARMED: begin
        if (bus_en) begin
          if (rw && w_vec_addr) begin
            w_state_next = ST_OVERLAY;
            w_nmi_next   = 1'b1;
            w_cont_next  = 1'b0;
          end else if (r_cnt == TMO_LAST) begin
            // CPU missed the edge: release NMI for one bus cycle so the next fall re-triggers it.
            w_nmi_next = 1'b1;
            w_cnt_next = '0;
          end else begin
            w_nmi_next = 1'b0;
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      ST_OVERLAY: begin
        w_nmi_next = 1'b1;
        if (w_run_next || w_step) begin
          w_cont_next = 1'b1;
        end
        // First opcode fetch outside the monitor page means RTI has completed.
        if (bus_en && sync && !w_ovl_page) begin
          if (w_run_next) begin
            w_state_next = ST_NORMAL;
          end else begin
            w_state_next = ST_ARMED;
            w_nmi_next   = 1'b0;
            w_cnt_next   = '0;
          end
        end
      end
      default: begin
        w_state_next = ST_NORMAL;
        w_nmi_next   = 1'b1;
      end
    endcase
  end

  always_comb begin
    overlay = 1'b0;
    case (r_state)
      ST_ARMED:   overlay = w_vec_addr;
      ST_OVERLAY: overlay = w_ovl_page;
      default:    overlay = 1'b0;
    endcase
  end

  assign nmi_n  = r_nmi_n;
  assign halted = ~r_run_mode;
  assign cont   = r_cont;
  assign state  = r_state;

endmodule

// File: tb/tb_cpu_break_sequencer.sv
// Self-checking bench for cpu_break_sequencer: directed scenarios plus randomized bus and
// button traffic compared against a rule-level reference model.
module tb_cpu_break_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_en = 1'b0;
  logic [15:0] A = 16'h0000;
  logic        rw = 1'b1;
  logic        sync = 1'b0;
  logic        b_runhalt = 1'b0;
  logic        b_step = 1'b0;
  logic        nmi_n;
  logic        overlay;
  logic        halted;
  logic        cont;
  logic [1:0]  state;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: plain description of the sequencer rules
  localparam int M_NORMAL = 0, M_ARMED = 1, M_OVERLAY = 2;
  int m_state;
  bit m_run;
  bit m_nmi;
  bit m_cont;
  int m_bus_count;

  bit g_ovl_obs;
  bit g_ovl_exp;
  bit g_verbose = 1'b1;

  cpu_break_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_en    (bus_en),
    .A         (A),
    .rw        (rw),
    .sync      (sync),
    .b_runhalt (b_runhalt),
    .b_step    (b_step),
    .nmi_n     (nmi_n),
    .overlay   (overlay),
    .halted    (halted),
    .cont      (cont),
    .state     (state)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  function automatic bit model_overlay(input logic [15:0] a);
    if (m_state == M_ARMED)   return (a == 16'hFFFA) || (a == 16'hFFFB);
    if (m_state == M_OVERLAY) return a[15:8] == 8'hFF;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_state = M_NORMAL; m_run = 1'b1; m_nmi = 1'b1; m_cont = 1'b0; m_bus_count = 0;
  endtask

  task automatic model_clock(input bit en, input logic [15:0] a, input bit r, input bit sy,
                             input bit rh, input bit st);
    bit run_after;
    run_after = rh ? !m_run : m_run;
    if (m_state == M_NORMAL) begin
      if (!run_after) begin
        m_state = M_ARMED; m_nmi = 1'b0; m_bus_count = 0;
      end
    end else if (m_state == M_ARMED) begin
      if (en) begin
        if (r && (a == 16'hFFFA || a == 16'hFFFB)) begin
          m_state = M_OVERLAY; m_nmi = 1'b1; m_cont = 1'b0;
        end else begin
          m_bus_count = m_bus_count + 1;
          if (m_bus_count == 1024) begin
            m_nmi = 1'b1; m_bus_count = 0;
          end else begin
            m_nmi = 1'b0;
          end
        end
      end
    end else begin
      m_nmi = 1'b1;
      if (run_after || (st && !rh)) m_cont = 1'b1;
      if (en && sy && a[15:8] != 8'hFF) begin
        if (run_after) m_state = M_NORMAL;
        else begin
          m_state = M_ARMED; m_nmi = 1'b0; m_bus_count = 0;
        end
      end
    end
    m_run = run_after;
  endtask

  // Called #1 after a rising edge: overlay is sampled before the edge, registers after it.
  task automatic step(input bit en, input logic [15:0] a, input bit r, input bit sy,
                      input bit rh, input bit st);
    bus_en = en; A = a; rw = r; sync = sy; b_runhalt = rh; b_step = st;
    #1;
    g_ovl_obs = overlay;
    g_ovl_exp = model_overlay(a);
    @(posedge clk); #1;
    model_clock(en, a, r, sy, rh, st);
    bus_en = 1'b0; b_runhalt = 1'b0; b_step = 1'b0; sync = 1'b0;
    if (g_verbose)
      $display("[TB] en=%0d A=%h rw=%0d sync=%0d rh=%0d st=%0d ovl=%0d -> state=%0d nmi_n=%0d halted=%0d cont=%0d",
               en, a, r, sy, rh, st, g_ovl_obs, state, nmi_n, halted, cont);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 16'h0200 + 16'(i), 1'b1, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if (nmi_n !== 1'b1 || g_ovl_obs !== 1'b0 || state !== 2'd0 || halted !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_run[%0d]: got nmi_n=%b ovl=%b state=%0d halted=%b want 1 0 0 0",
                 i, nmi_n, g_ovl_obs, state, halted);
      end
    end
  endtask

  task automatic test_halt();
    step(1'b0, 16'h0210, 1'b1, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (nmi_n !== 1'b0 || state !== 2'd1 || halted !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_nmi_fall: got nmi_n=%b state=%0d halted=%b want 0 1 1", nmi_n, state, halted);
    end
    step(1'b1, 16'hFFFA, 1'b1, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (g_ovl_obs !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_vec_overlay: got %b want 1", g_ovl_obs);
    end
    n_tests++;
    if (state !== 2'd2 || nmi_n !== 1'b1 || cont !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_enter_overlay: got state=%0d nmi_n=%b cont=%b want 2 1 0", state, nmi_n, cont);
    end
    step(1'b1, 16'hFFFB, 1'b1, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (g_ovl_obs !== 1'b1 || state !== 2'd2) begin
      n_fail++;
      $display("FAIL halt_vec_hi: got ovl=%b state=%0d want 1 2", g_ovl_obs, state);
    end
  endtask

  task automatic test_step();
    step(1'b1, 16'hFF10, 1'b1, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (g_ovl_obs !== 1'b1 || state !== 2'd2 || cont !== 1'b0) begin
      n_fail++;
      $display("FAIL step_monitor_fetch: got ovl=%b state=%0d cont=%b want 1 2 0", g_ovl_obs, state, cont);
    end
    step(1'b0, 16'hFF20, 1'b1, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (cont !== 1'b1 || halted !== 1'b1) begin
      n_fail++;
      $display("FAIL step_cont: got cont=%b halted=%b want 1 1", cont, halted);
    end
    step(1'b1, 16'h0300, 1'b1, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (g_ovl_obs !== 1'b0 || state !== 2'd1 || nmi_n !== 1'b0) begin
      n_fail++;
      $display("FAIL step_rearm: got ovl=%b state=%0d nmi_n=%b want 0 1 0", g_ovl_obs, state, nmi_n);
    end
  endtask

  task automatic test_runhalt_step();
    step(1'b1, 16'hFFFA, 1'b1, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (state !== 2'd2 || cont !== 1'b0) begin
      n_fail++;
      $display("FAIL rs_reenter: got state=%0d cont=%b want 2 0", state, cont);
    end
    step(1'b0, 16'hFF30, 1'b1, 1'b0, 1'b1, 1'b1);
    n_tests++;
    if (halted !== 1'b0 || cont !== 1'b1 || state !== 2'd2) begin
      n_fail++;
      $display("FAIL rs_same_clk: got halted=%b cont=%b state=%0d want 0 1 2", halted, cont, state);
    end
    step(1'b1, 16'h0300, 1'b1, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (state !== 2'd0 || nmi_n !== 1'b1) begin
      n_fail++;
      $display("FAIL rs_resume: got state=%0d nmi_n=%b want 0 1", state, nmi_n);
    end
  endtask

  task automatic test_timeout();
    int bad;
    step(1'b0, 16'h0400, 1'b1, 1'b0, 1'b1, 1'b0);
    g_verbose = 1'b0;
    bad = 0;
    for (int i = 0; i < 1023; i++) begin
      step(1'b1, 16'($urandom_range(0, 16'hFFF9)), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
      if (nmi_n !== 1'b0 || state !== 2'd1) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL tmo_hold_low: got %0d cycles with nmi_n high want 0", bad);
    end
    step(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (nmi_n !== 1'b1 || state !== 2'd1) begin
      n_fail++;
      $display("FAIL tmo_pulse: got nmi_n=%b state=%0d want 1 1", nmi_n, state);
    end
    repeat (3) step(1'b0, 16'h1235, 1'b1, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (nmi_n !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_pulse_idle: got nmi_n=%b want 1", nmi_n);
    end
    step(1'b1, 16'h1236, 1'b1, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (nmi_n !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_pulse_end: got nmi_n=%b want 0", nmi_n);
    end
    bad = 0;
    for (int i = 0; i < 1022; i++) begin
      step(1'b1, 16'($urandom_range(0, 16'h7FFF)), 1'b1, 1'b0, 1'b0, 1'b0);
      if (nmi_n !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL tmo_restart_low: got %0d cycles with nmi_n high want 0", bad);
    end
    step(1'b1, 16'h2000, 1'b1, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (nmi_n !== 1'b1 || nmi_n !== m_nmi) begin
      n_fail++;
      $display("FAIL tmo_second_pulse: got nmi_n=%b want 1 (model %b)", nmi_n, m_nmi);
    end
    g_verbose = 1'b1;
  endtask

  task automatic test_async_reset();
    step(1'b1, 16'hFFFA, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'hFF00, 1'b1, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (state !== 2'd2 || cont !== 1'b1) begin
      n_fail++;
      $display("FAIL ar_setup: got state=%0d cont=%b want 2 1", state, cont);
    end
    rst_n = 1'b0;
    model_reset();
    #2;
    n_tests++;
    if (state !== 2'd0 || nmi_n !== 1'b1 || cont !== 1'b0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL ar_immediate: got state=%0d nmi_n=%b cont=%b halted=%b want 0 1 0 0",
               state, nmi_n, cont, halted);
    end
    A = 16'hFFFC; rw = 1'b1;
    #1;
    n_tests++;
    if (overlay !== 1'b0) begin
      n_fail++;
      $display("FAIL ar_reset_vector: got overlay=%b want 0", overlay);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 16'hFFFC, 1'b1, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (g_ovl_obs !== 1'b0 || state !== 2'd0 || nmi_n !== 1'b1) begin
      n_fail++;
      $display("FAIL ar_after_release: got ovl=%b state=%0d nmi_n=%b want 0 0 1", g_ovl_obs, state, nmi_n);
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    int sel;
    int bad;
    apply_reset();
    g_verbose = 1'b0;
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      sel = int'($urandom_range(0, 7));
      if (sel == 0)      a = 16'hFFFA;
      else if (sel == 1) a = 16'hFFFB;
      else if (sel < 4)  a = {8'hFF, 8'($urandom)};
      else               a = 16'($urandom_range(0, 16'h7FFF));
      step(1'($urandom_range(0, 3) != 0), a, 1'($urandom_range(0, 3) != 0), 1'($urandom),
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 7) == 0));
      if (state !== 2'(m_state) || nmi_n !== m_nmi || halted !== !m_run ||
          cont !== m_cont || g_ovl_obs !== g_ovl_exp) begin
        bad++;
        if (bad <= 5)
          $display("FAIL rand[%0d]: got state=%0d nmi_n=%b halted=%b cont=%b ovl=%b want %0d %b %b %b %b",
                   i, state, nmi_n, halted, cont, g_ovl_obs, m_state, m_nmi, !m_run, m_cont, g_ovl_exp);
      end
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL rand_total: got %0d mismatching cycles want 0", bad);
    end
    g_verbose = 1'b1;
  endtask

  initial begin
    test_reset();
    test_halt();
    test_step();
    test_runhalt_step();
    test_timeout();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
